// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_4x1_rr_arbiter_pkg
// Shared constants and types for the round-robin 4:1 mux arbiter.
//   N_REQ : number of requesters sharing the mux
//   IDX_W : width of a requester index / select value
//   idx_t : requester index type (also the {s1,s0} select encoding)
// ---------------------------------------------------------------------------
package mux_4x1_rr_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/mux_4x1_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Purely combinational round-robin picker for four requesters.
// The search starts at ptr and walks ptr+1, ptr+2, ptr+3 (mod 4); the first
// index with req set wins.
//   req[3:0]    : request vector
//   ptr[1:0]    : index with highest priority this cycle
//   any         : at least one request is set
//   winner[1:0] : chosen index (only meaningful when any is high)
// ---------------------------------------------------------------------------
module rr_pick4
    import mux_4x1_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] winner
);

    logic [N_REQ-1:0] rot;
    idx_t             off;

    // Rotate so that bit 0 of rot is the requester at ptr, then take the
    // lowest set bit; adding ptr back un-rotates the offset into an index.
    always_comb begin
        rot = '0;
        off = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rot[j] = req[idx_t'(ptr + idx_t'(j))];
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = idx_t'(j);
            end
        end
    end

    assign any    = |req;
    assign winner = ptr + off;

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_4x1_rr_arbiter
// Shares one 4:1 word mux between four requesters with round-robin
// arbitration and registers the chosen word into a single output slot with
// a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req[3:0]            : per-requester request (data valid)
//   i0..i3 [WIDTH-1:0]  : requester data words
//   ack[3:0]            : one-hot, combinational; word k captured this edge
//   out [WIDTH-1:0]     : registered selected word
//   out_valid           : out holds an undelivered word
//   out_ready           : consumer takes out this cycle
//   s1, s0              : registered index of the word held in out
// ---------------------------------------------------------------------------
module mux_4x1_rr_arbiter
    import mux_4x1_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s0,
    output logic             s1
);

    idx_t             ptr;
    idx_t             winner_p0;
    logic             any_p0;
    logic             cap_p0;
    logic [WIDTH-1:0] word_p0;

    logic [WIDTH-1:0] out_p1;
    idx_t             sel_p1;
    logic             vld_p1;

    // ---- stage p0: arbitration, data mux, handshake decode ----
    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any_p0),
        .winner (winner_p0)
    );

    // Slot can take a word when empty or when it is being drained now.
    assign cap_p0 = !vld_p1 || out_ready;

    always_comb begin
        case (winner_p0)
            2'd0:    word_p0 = i0;
            2'd1:    word_p0 = i1;
            2'd2:    word_p0 = i2;
            default: word_p0 = i3;
        endcase
    end

    // rst_n gates ack so nothing is handed off while the slot is in reset.
    always_comb begin
        ack = '0;
        if (rst_n && cap_p0 && any_p0) begin
            ack[winner_p0] = 1'b1;
        end
    end

    // ---- stage p1: output slot and priority pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            sel_p1 <= '0;
            vld_p1 <= 1'b0;
            ptr    <= '0;
        end else if (cap_p0) begin
            if (any_p0) begin
                out_p1 <= word_p0;
                sel_p1 <= winner_p0;
                vld_p1 <= 1'b1;
                ptr    <= winner_p0 + idx_t'(1);
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out       = out_p1;
    assign out_valid = vld_p1;
    assign s1        = sel_p1[1];
    assign s0        = sel_p1[0];

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_4x1_rr_arbiter
// Directed bench for mux_4x1_rr_arbiter. Inputs change just after the
// falling edge; all outputs are sampled in the second half of the cycle,
// away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mux_4x1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] ack;
    logic [3:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       s0, s1;

    int n_cmp = 0;
    int n_err = 0;

    mux_4x1_rr_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .ack       (ack),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s0        (s0),
        .s1        (s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] rot_out [5];
    logic [1:0] rot_sel [5];

    initial begin
        rot_out = '{4'hA, 4'hF, 4'h0, 4'h5, 4'hA};
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with random activity on the inputs
        rst_n     = 1'b0;
        req       = 4'($urandom);
        i0        = 4'($urandom);
        i1        = 4'($urandom);
        i2        = 4'($urandom);
        i3        = 4'($urandom);
        out_ready = 1'($urandom);
        tick();
        req = 4'b1111;
        tick();
        check("rst_out",   32'(out),       32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_sel",   32'({s1, s0}),  32'h0);
        check("rst_ack",   32'(ack),       32'h0);

        // Release with everyone requesting; requester 0 first, then rotate
        rst_n     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        i0 = 4'hA; i1 = 4'hF; i2 = 4'h0; i3 = 4'h5;
        #1;
        check("rel_ack", 32'(ack), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rot_out%0d", k),   32'(out),       32'(rot_out[k]));
            check($sformatf("rot_sel%0d", k),   32'({s1, s0}),  32'(rot_sel[k]));
            check($sformatf("rot_valid%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("rot_ack%0d", k),   32'(ack),       32'(4'b0001 << ((k + 1) % 4)));
        end

        // Backpressure: slot full, consumer stalls for 5 cycles
        out_ready = 1'b0;
        #1;
        check("bp_ack_now", 32'(ack), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_ack%0d", k),   32'(ack),       32'h0);
            check($sformatf("bp_out%0d", k),   32'(out),       32'hA);
            check($sformatf("bp_sel%0d", k),   32'({s1, s0}),  32'h0);
            check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ack", 32'(ack), 32'b0010);
        tick();
        check("bp_resume_out", 32'(out),      32'hF);
        check("bp_resume_sel", 32'({s1, s0}), 32'h1);

        // Idle drain: valid drops, data/select hold, ptr stays at 2
        req = 4'b0000;
        #1;
        check("idle_ack", 32'(ack), 32'h0);
        tick();
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_out",   32'(out),       32'hF);
        check("idle_sel",   32'({s1, s0}),  32'h1);

        // Single requester 1
        req = 4'b0010;
        i1  = 4'hF;
        #1;
        check("single_ack", 32'(ack), 32'b0010);
        tick();
        check("single_out",   32'(out),       32'hF);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_sel",   32'({s1, s0}),  32'h1);

        // Grant to requester 2 moves ptr to 3
        req = 4'b0100;
        i2  = 4'h6;
        #1;
        check("g2_ack", 32'(ack), 32'b0100);
        tick();
        check("g2_out", 32'(out),      32'h6);
        check("g2_sel", 32'({s1, s0}), 32'h2);

        // Pointer wrap: ptr=3, req=0101 -> 0 wins, then ptr=1 -> 2 wins
        req = 4'b0101;
        i0  = 4'h9;
        #1;
        check("wrap_ack0", 32'(ack), 32'b0001);
        tick();
        check("wrap_out0", 32'(out),      32'h9);
        check("wrap_sel0", 32'({s1, s0}), 32'h0);
        check("wrap_ack1", 32'(ack),      32'b0100);
        tick();
        check("wrap_out1",   32'(out),       32'h6);
        check("wrap_sel1",   32'({s1, s0}),  32'h2);
        check("wrap_valid1", 32'(out_valid), 32'h1);

        // Asynchronous reset mid-stream, away from any clock edge
        req = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'h0);
        check("mid_sel",   32'({s1, s0}),  32'h0);
        check("mid_out",   32'(out),       32'h0);
        check("mid_ack",   32'(ack),       32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ack", 32'(ack), 32'b0001);
        tick();
        check("mid_rel_out", 32'(out),      32'h9);
        check("mid_rel_sel", 32'({s1, s0}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4:1 word multiplexer between four requesters and registers the selected word into a single output slot with a valid/ready handshake. It sits in front of any downstream consumer that previously took a static mux output. It turns the mux select lines `s1`/`s0` into an arbitrated, fair, back-pressurable channel.

## Interface
Parameters:
- `WIDTH`, default 4: data word width of each requester input and of `out`.

Ports:
- `clk` — input, 1: single clock; all state updates on the rising edge.
- `rst_n` — input, 1: asynchronous, active-low reset.
- `req` — input, 4: request per requester; `req[k]` high means the data on input `k` is valid.
- `i0`, `i1`, `i2`, `i3` — input, WIDTH each: requester data words.
- `ack` — output, 4: one-hot, combinational; `ack[k]` high means the word on input `k` is captured at this edge.
- `out` — output, WIDTH: registered selected word.
- `out_valid` — output, 1: `out` holds an undelivered word.
- `out_ready` — input, 1: consumer accepts `out` this cycle.
- `s0`, `s1` — output, 1 each: registered select; `{s1,s0}` is the index of the requester whose word is in `out`.

## Operation
- Transfer from requester `k` occurs when `req[k] && ack[k]`. Requester holds `req[k]` and its data stable until acked.
- Capture enable: `cap = !out_valid || out_ready` (slot empty or being drained this cycle).
- Winner selection:
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first index with `req` set wins.
  - `ptr` is a 2-bit register.
- When `cap` is high and `req` is nonzero:
  - `ack[winner]=1`; all other `ack` bits 0.
  - At the edge: `out <= i[winner]`, `{s1,s0} <= winner`, `out_valid <= 1`, `ptr <= winner+1` (wraps 3→0).
- When `cap` is high and `req` is zero: `ack=0`. If `out_ready` is high, then `out_valid <= 0`; `out` and `s1`/`s0` hold their last values.
- When `cap` is low (full slot, `out_ready=0`): `ack=0`. `out`, `s1`/`s0`, `ptr` and `out_valid` all hold.
- Simultaneous drain and capture (`out_valid && out_ready && req!=0`): the new word replaces the old at the same edge, with no bubble.
- `ptr` changes only on a capture. Idle cycles do not rotate priority.
- Fairness: any requester held high is granted within 4 captures.

## Timing
- Reset (`rst_n` low, asynchronous): `out=0`, `out_valid=0`, `s0=0`, `s1=0`, `ptr=0`.
  - `ack` is forced to 0 while `rst_n` is low.
  - First release: a simultaneous `req=4'b1111` grants requester 0.
- Latency: `ack` is in cycle N; `out`/`out_valid`/`s1`/`s0` update after the edge ending cycle N.
- Throughput: one word per cycle while `out_ready` is held high and any `req` is set.
- `ack` depends combinationally on `req`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `i0`–`i3` to any output.
- Reset mid-operation: a pending word in `out` is discarded and no `ack` is issued. Requesters keep `req` high and are served after reset release.

## Structure
- Shared package holds:
  - `N_REQ=4` and `IDX_W=2`.
  - The select index type (`logic [IDX_W-1:0]`).
- Sub-module `rr_pick4`: purely combinational.
  - Inputs `req[3:0]`, `ptr[1:0]`.
  - Outputs `any`, `winner[1:0]`.
  - Rotate, priority-encode, un-rotate.
- The top level holds:
  - the data mux (indexed by `winner`);
  - the `out`/`s1`/`s0`/`out_valid`/`ptr` registers;
  - the `ack` decode gated by `cap`.

## Test plan
- Reset: drive random `req`/data with `rst_n=0` → `out=0`, `out_valid=0`, `s1s0=00`, `ack=0000`. Release `rst_n` with `req=1111` → `ack=0001`.
- Single requester: `req=0010`, `i1=4'hF`, `out_ready=1` → `ack=0010` that cycle. Next cycle `out=4'hF`, `out_valid=1`, `s1s0=01`.
- Rotation: `i0=4'hA`, `i1=4'hF`, `i2=4'h0`, `i3=4'h5`, `req=1111`, `out_ready=1` → `out` sequence A, F, 0, 5, A and `s1s0` sequence 00, 01, 10, 11, 00 on consecutive cycles.
- Backpressure: with `out_valid=1`, hold `out_ready=0` for 5 cycles under `req=1111` → `ack=0000`, and `out`/`s1s0` stable for all 5 cycles. Raise `out_ready` → next requester in order is acked the same cycle and `out` updates with no bubble.
- Pointer wrap: after a grant to requester 2 (`ptr=3`), drive `req=0101` → `ack=0001` (requester 0 wins over 2). Then `ptr=1`, and with `req=0101` → `ack=0100`.
- Reset mid-stream: assert `rst_n=0` asynchronously while `out_valid=1`, `s1s0=10` → `out_valid=0` and `s1s0=00` immediately, without waiting for a clock edge. After release, `req=1111` → requester 0 granted first.
